// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer
//   Multi-cycle unsigned shift-add multiplier controller wrapped around an
//   external, purely combinational WIDTH-bit ALU. Holds the product/multiplier
//   shift register and the step counter. It drives the ALU operands and opcode,
//   and each RUN cycle it captures the ALU sum and carry-out.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 multiply request, sampled only in IDLE
//   multiplicand          operand A, captured on the accepting edge
//   multiplier            operand B, captured on the accepting edge
//   busy                  high while stepping (RUN)
//   done                  one-cycle pulse when product is final
//   product               2*WIDTH-bit result, held until the next accepted start
//   alu_a, alu_b          ALU operands (upper product half, multiplicand or 0)
//   alu_cin               ALU carry-in, constant 0
//   alu_op                ALU select {alu2,alu1,alu0}
//   alu_result, alu_cout  ALU sum and carry-out, same cycle
module alu_mult_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] OP_ADD  = 3'b010,
    parameter logic [2:0] OP_IDLE = 3'b000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_cin,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   p_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [CNT_W-1:0]     cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            p_q     <= '0;
            mcand_q <= '0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand_q <= multiplicand;
                        p_q     <= {{WIDTH{1'b0}}, multiplier};
                        cnt     <= '0;
                    end
                end
                S_RUN: begin
                    // {cout, sum, low half} shifted right by one: the carry-out
                    // lands in the top bit, the consumed multiplier bit drops off.
                    p_q <= {alu_cout, alu_result, p_q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        alu_op     = OP_IDLE;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                alu_op = OP_ADD;
                alu_a  = p_q[2*WIDTH-1:WIDTH];
                alu_b  = p_q[0] ? mcand_q : '0;
                if (cnt == LAST_STEP) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign alu_cin = 1'b0;
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign product = p_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer: the stimulus side records each
// accepted request (operands, accept edge, expected product); a negedge monitor
// checks busy/ALU drive every cycle and pops/compares on each done pulse.
module tb_alu_mult_sequencer;

    localparam int W = 32;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_IDLE = 3'b000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           busy, done, alu_cin, alu_cout;
    logic [2*W-1:0] product;
    logic [W-1:0]   alu_a, alu_b, alu_result;
    logic [2:0]     alu_op;

    alu_mult_sequencer #(.WIDTH(W), .OP_ADD(OP_ADD), .OP_IDLE(OP_IDLE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    // Behavioural ALU: ADD gives a+b+cin with carry-out, other codes act as AND.
    always_comb begin
        if (alu_op == OP_ADD) {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
        else begin
            alu_result = alu_a & alu_b;
            alu_cout   = 1'b0;
        end
    end

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned exp;
        int              acc;
        logic [W-1:0]    mc;
    } req_t;

    req_t q[$];
    int   cyc = 0;
    int   next_free = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   finished = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic summary();
        if (!finished) begin
            finished = 1;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    endtask

    // Reference model: one request in flight; after acceptance the unit can next
    // accept W+2 edges later (W steps, one DONE cycle, one IDLE sample).
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            next_free = cyc + 1;
        end else if (start && cyc >= next_free) begin
            q.push_back('{exp: longint'(multiplicand) * longint'(multiplier), acc: cyc, mc: multiplicand});
            next_free = cyc + W + 2;
        end
        if (cyc > 20000) begin
            n_fail++;
            $display("FAIL watchdog: got %0d cycles expected <= 20000", cyc);
            summary();
        end
    end

    // Monitor.
    always @(negedge clk) begin
        if (!reset && !finished) begin
            logic busy_exp;
            busy_exp = (q.size() > 0) && ((cyc - q[0].acc) < W);
            chk("busy", 64'(busy), 64'(busy_exp));
            if (busy) begin
                chk("alu_op_run", 64'(alu_op), 64'(OP_ADD));
                chk("alu_cin", 64'(alu_cin), 64'd0);
                if (q.size() > 0) begin
                    if (q[0].mc == '0) chk("alu_b_zero", 64'(alu_b), 64'd0);
                    else chk("alu_b_sel", 64'((alu_b == '0) || (alu_b == q[0].mc)), 64'd1);
                end
            end else begin
                chk("alu_op_idle", 64'(alu_op), 64'(OP_IDLE));
                chk("alu_ab_idle", {alu_a, alu_b}, 64'd0);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    chk("product", product, q[0].exp);
                    chk("done_latency", 64'(cyc - q[0].acc), 64'(W));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic wait_free();
        int guard = 0;
        while ((cyc + 1 < next_free || q.size() != 0) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("wait_free_timeout", 64'(guard), 64'd0);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_free();
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        reset = 1'b0;

        issue(32'd3, 32'd5);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(32'd0, 32'h1234_5678);
        issue(32'h8000_0000, 32'd2);

        // Requests during RUN with new operands must be ignored.
        issue(32'd1000, 32'd777);
        repeat (3) @(posedge clk);
        #0;
        multiplicand = $urandom; multiplier = $urandom; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        multiplicand = $urandom; multiplier = $urandom; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;

        // Asynchronous reset in the middle of a run.
        issue(32'd11, 32'd13);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_product", product, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        issue(32'd7, 32'd6);

        // Back-to-back: start held high, operands changing every cycle.
        wait_free();
        start = 1'b1;
        for (int i = 0; i < 5 * (W + 2); i++) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0;

        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            issue(a, b);
        end

        wait_free();
        repeat (3) @(posedge clk);
        summary();
    end

endmodule
